// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - shared calendar constants, FSM encoding and days-in-month function
package calendar_pkg;

    localparam int DAY_W = 5;
    localparam int MON_W = 4;

    localparam logic [MON_W-1:0] JAN = 4'd1;
    localparam logic [MON_W-1:0] FEB = 4'd2;
    localparam logic [MON_W-1:0] MAR = 4'd3;
    localparam logic [MON_W-1:0] APR = 4'd4;
    localparam logic [MON_W-1:0] MAY = 4'd5;
    localparam logic [MON_W-1:0] JUN = 4'd6;
    localparam logic [MON_W-1:0] JUL = 4'd7;
    localparam logic [MON_W-1:0] AUG = 4'd8;
    localparam logic [MON_W-1:0] SEP = 4'd9;
    localparam logic [MON_W-1:0] OCT = 4'd10;
    localparam logic [MON_W-1:0] NOV = 4'd11;
    localparam logic [MON_W-1:0] DEC = 4'd12;

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_CHK = 1'b1;

    function automatic logic [DAY_W-1:0] dim(input logic [MON_W-1:0] month, input logic leap);
        case (month)
            FEB:                dim = leap ? 5'd29 : 5'd28;
            APR, JUN, SEP, NOV: dim = 5'd30;
            default:            dim = 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/date_counter_days_in_month.sv
// rtl/date_counter_days_in_month.sv - combinational month + leap flag to days in month
module days_in_month
    import calendar_pkg::*;
(
    input  logic [MON_W-1:0] i_month,
    input  logic             i_leap,
    output logic [DAY_W-1:0] o_dim
);

    assign o_dim = dim(i_month, i_leap);

endmodule

// File: rtl/date_counter.sv
// rtl/date_counter.sv - day/month/year calendar counter with validated date load
module date_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_W    = 14,
    parameter int YEAR_MAX  = 9999,
    parameter int YEAR_INIT = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              day_tick,
    input  logic              set_en,
    input  logic [DAY_W-1:0]  set_day,
    input  logic [MON_W-1:0]  set_month,
    input  logic [YEAR_W-1:0] set_year,
    input  logic              leap_year,
    output logic [DAY_W-1:0]  day,
    output logic [MON_W-1:0]  month,
    output logic [YEAR_W-1:0] year,
    output logic              year_wrap,
    output logic              set_err,
    output logic              busy
);

    localparam logic [YEAR_W-1:0] C_YEAR_MAX  = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] C_YEAR_INIT = YEAR_W'(YEAR_INIT);

    logic [0:0]        r_state;
    logic              r_pend;
    logic [DAY_W-1:0]  r_day;
    logic [MON_W-1:0]  r_month;
    logic [YEAR_W-1:0] r_year;
    logic              r_wrap;
    logic              r_err;

    logic [DAY_W-1:0]  w_dim;
    logic [DAY_W-1:0]  w_set_day;
    logic [MON_W-1:0]  w_set_month;
    logic [YEAR_W-1:0] w_set_year;
    logic              w_clamped;

    // leap_year follows r_year through the external encoder, so w_dim is valid in CHK
    days_in_month u_dim (
        .i_month (r_month),
        .i_leap  (leap_year),
        .o_dim   (w_dim)
    );

    assign w_set_day   = (set_day == '0) ? 5'd1 : set_day;
    assign w_set_month = (set_month == '0) ? JAN : ((set_month > DEC) ? DEC : set_month);
    assign w_set_year  = (set_year > C_YEAR_MAX) ? C_YEAR_MAX : set_year;
    assign w_clamped   = (set_day == '0) || (set_month == '0) || (set_month > DEC)
                      || (set_year > C_YEAR_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pend  <= 1'b0;
            r_day   <= 5'd1;
            r_month <= JAN;
            r_year  <= C_YEAR_INIT;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
            if (r_state == ST_RUN) begin
                if (set_en) begin
                    r_day   <= w_set_day;
                    r_month <= w_set_month;
                    r_year  <= w_set_year;
                    r_err   <= w_clamped;
                    r_state <= ST_CHK;
                    if (day_tick) begin
                        r_pend <= 1'b1;
                    end
                end else if (day_tick || r_pend) begin
                    r_pend <= 1'b0;
                    if (r_day < w_dim) begin
                        r_day <= r_day + 5'd1;
                    end else begin
                        r_day <= 5'd1;
                        if (r_month < DEC) begin
                            r_month <= r_month + 4'd1;
                        end else begin
                            r_month <= JAN;
                            if (r_year == C_YEAR_MAX) begin
                                r_year <= '0;
                                r_wrap <= 1'b1;
                            end else begin
                                r_year <= r_year + 1'b1;
                            end
                        end
                    end
                end
            end else begin
                // day range can only be checked once the new year has reached the encoder
                if (r_day > w_dim) begin
                    r_day <= w_dim;
                    r_err <= 1'b1;
                end
                if (day_tick) begin
                    r_pend <= 1'b1;
                end
                r_state <= ST_RUN;
            end
        end
    end

    assign day       = r_day;
    assign month     = r_month;
    assign year      = r_year;
    assign year_wrap = r_wrap;
    assign set_err   = r_err;
    assign busy      = (r_state == ST_CHK);

endmodule
